// File: rtl/cpu_controller_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared types and constants for the cpu_controller slice.
//   - instruction / register-number widths
//   - FSM state encoding
//   - opcode / op field values, vsel writeback codes, ALUop codes
//   - route_decode(): DECODE-state routing on {opcode, op}
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int IW = 16;  // instruction width
  localparam int RW = 3;   // register-number width

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
  } state_e;

  // opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // writeback source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Where DECODE goes next; S_WAIT means the encoding is unsupported.
  function automatic state_e route_decode(input logic [2:0] opc, input logic [1:0] op);
    state_e nxt;
    nxt = S_WAIT;
    if (opc == OPC_MOV && op == OP_MOV_IMM)      nxt = S_WR_IMM;
    else if (opc == OPC_MOV && op == OP_MOV_REG) nxt = S_GET_B;
    else if (opc == OPC_ALU && op == OP_MVN)     nxt = S_GET_B;
    else if (opc == OPC_ALU)                     nxt = S_GET_A;  // ADD, CMP, AND
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_if: host handshake plus datapath control bundle of cpu_controller.
//   host -> ctrl : s (start), load (capture in into IR), in (instruction word)
//   ctrl -> host : w (waiting), bad_op (unsupported encoding pulse)
//   ctrl -> datapath : readnum, writenum, write, vsel, loada, loadb, asel,
//                      bsel, shift, ALUop, loadc, loads, sximm5, sximm8
// modport master = host/datapath side, modport slave = controller side.
// -----------------------------------------------------------------------------
interface cpu_ctrl_if;
  import cpu_pkg::*;

  logic          s;
  logic          load;
  logic [IW-1:0] in;
  logic          w;
  logic          bad_op;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic [1:0]    vsel;
  logic          loada;
  logic          loadb;
  logic          asel;
  logic          bsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic          loadc;
  logic          loads;
  logic [IW-1:0] sximm5;
  logic [IW-1:0] sximm8;

  modport master (
    output s, load, in,
    input  w, bad_op, readnum, writenum, write, vsel, loada, loadb, asel,
           bsel, shift, ALUop, loadc, loads, sximm5, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, bad_op, readnum, writenum, write, vsel, loada, loadb, asel,
           bsel, shift, ALUop, loadc, loads, sximm5, sximm8
  );
endinterface

// File: rtl/cpu_controller_instr_dec.sv
// -----------------------------------------------------------------------------
// instr_dec: purely combinational split of the instruction register.
//   ir_i      : instruction register contents
//   opcode_o  : IR[15:13]      op_o : IR[12:11]
//   rn_o      : IR[10:8]       rd_o : IR[7:5]      rm_o : IR[2:0]
//   sh_o      : IR[4:3]
//   sximm5_o  : IR[4:0] sign-extended      sximm8_o : IR[7:0] sign-extended
// -----------------------------------------------------------------------------
module instr_dec
  import cpu_pkg::*;
(
  input  logic [IW-1:0] ir_i,
  output logic [2:0]    opcode_o,
  output logic [1:0]    op_o,
  output logic [RW-1:0] rn_o,
  output logic [RW-1:0] rd_o,
  output logic [RW-1:0] rm_o,
  output logic [1:0]    sh_o,
  output logic [IW-1:0] sximm5_o,
  output logic [IW-1:0] sximm8_o
);
  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{(IW-5){ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{(IW-8){ir_i[7]}}, ir_i[7:0]};
endmodule

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller: instruction register plus Moore sequencing FSM for datapath.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (state=WAIT, IR=0)
//   bus     : cpu_ctrl_if.slave -- s/load/in in; w, bad_op and all datapath
//             controls out. Every output is a function of state and IR only.
// -----------------------------------------------------------------------------
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cpu_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh;
  logic [IW-1:0] sximm5, sximm8;

  instr_dec u_dec (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .sh_o     (sh),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8)
  );

  // Only accept a new word while idle so a running instruction keeps its IR.
  assign ir_d = (bus.load && state_q == S_WAIT) ? bus.in : ir_q;

  // State and IR register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred for state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (bus.s) state_d = S_DECODE;
      S_DECODE: state_d = route_decode(opcode, op);
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.w        = 1'b0;
    bus.bad_op   = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.vsel     = VSEL_C;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.ALUop    = ALU_ADD;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    case (state_q)
      S_WAIT:   bus.w = 1'b1;
      S_DECODE: bus.bad_op = (route_decode(opcode, op) == S_WAIT);
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      S_EXEC: begin
        // MOV-register passes B through as 0 + B; MVN ignores A anyway.
        bus.ALUop = (opcode == OPC_ALU) ? op : ALU_ADD;
        bus.asel  = (opcode == OPC_MOV) || (opcode == OPC_ALU && op == OP_MVN);
        bus.loadc = 1'b1;
        bus.loads = (opcode == OPC_ALU && op == OP_CMP);
      end
      S_WR_REG: begin
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
      end
      S_WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = VSEL_IMM8;
        bus.write    = 1'b1;
      end
      default: bus.w = 1'b1;
    endcase
  end

  assign bus.shift  = sh;
  assign bus.sximm5 = sximm5;
  assign bus.sximm8 = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller: directed bench for cpu_controller. A small behavioural
// datapath (register file, A/B/C, shifter, ALU) is driven by the controller's
// outputs; a scoreboard queue holds the hand-computed register writes, status
// results and bad-op pulses, and a monitor compares them as they appear.
// -----------------------------------------------------------------------------
module tb_cpu_controller;
  import cpu_pkg::*;

  localparam int EV_WR  = 0;
  localparam int EV_ST  = 1;
  localparam int EV_BAD = 2;

  typedef struct {
    int          kind;
    logic [2:0]  num;
    logic [15:0] value;
  } ev_t;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  cpu_ctrl_if bus ();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [15:0] rf [8];
  logic [15:0] a_q, b_q, c_q;
  logic [15:0] sout, ain, bin, alu, wb;

  initial for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
  initial begin a_q = '0; b_q = '0; c_q = '0; end

  always_comb begin
    case (bus.shift)
      2'b00:   sout = b_q;
      2'b01:   sout = {b_q[14:0], 1'b0};
      2'b10:   sout = {1'b0, b_q[15:1]};
      default: sout = {b_q[15], b_q[15:1]};
    endcase
    ain = bus.asel ? 16'h0000 : a_q;
    bin = bus.bsel ? bus.sximm5 : sout;
    case (bus.ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
    case (bus.vsel)
      2'b00:   wb = c_q;
      2'b10:   wb = bus.sximm8;
      default: wb = 16'hDEAD;
    endcase
  end

  always @(posedge clk) begin
    if (bus.write) rf[bus.writenum] <= wb;
    if (bus.loada) a_q <= rf[bus.readnum];
    if (bus.loadb) b_q <= rf[bus.readnum];
    if (bus.loadc) c_q <= alu;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ev_t e;
    int  kind_act;
    if (reset_n && (bus.write || bus.loads || bus.bad_op)) begin
      kind_act = bus.bad_op ? EV_BAD : (bus.loads ? EV_ST : EV_WR);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(kind_act + 1), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(kind_act), 32'(e.kind));
        if (e.kind == EV_WR) begin
          check("writenum", {29'd0, bus.writenum}, {29'd0, e.num});
          check("wb_data", {16'd0, wb}, {16'd0, e.value});
        end else if (e.kind == EV_ST) begin
          check("cmp_result", {16'd0, alu}, {16'd0, e.value});
          check("cmp_no_write", {31'd0, bus.write}, 32'd0);
        end else begin
          check("bad_no_enables",
                {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 32'd0);
        end
      end
    end
  end

  task automatic expect_ev(input int kind, input logic [2:0] num, input logic [15:0] value);
    ev_t e;
    e.kind = kind; e.num = num; e.value = value;
    exp_q.push_back(e);
  endtask

  // Issue one instruction (load+s together) and check w over its lifetime.
  // inject_k > 0 attempts a load of 16'hD3FF before edge inject_k.
  task automatic do_instr(input string name, input logic [15:0] word, input int lat,
                          input int inject_k, input bit is_bad);
    @(negedge clk);
    bus.in = word; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (inject_k == k) begin
        bus.load = 1'b1; bus.in = 16'hD3FF;
      end else begin
        bus.load = 1'b0;
      end
      check({name, "_w_busy"}, {31'd0, bus.w}, 32'd0);
      if (is_bad && k == 1) check({name, "_bad_op_pulse"}, {31'd0, bus.bad_op}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.load = 1'b0;
    check({name, "_w_done"}, {31'd0, bus.w}, 32'd1);
    if (is_bad) check({name, "_bad_op_clear"}, {31'd0, bus.bad_op}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;
    #1;
    check("reset_w", {31'd0, bus.w}, 32'd1);
    check("reset_enables",
          {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 32'd0);
    check("reset_sel", {26'd0, bus.vsel, bus.asel, bus.bsel, bus.ALUop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-instruction: ADD aborted in GET_B, no write may occur.
    @(negedge clk);
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_w", {31'd0, bus.w}, 32'd1);
    check("midrst_enables",
          {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 32'd0);
    check("midrst_ir_clear", {16'd0, bus.sximm8}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    expect_ev(EV_WR, 3'd0, 16'h0007);
    do_instr("mov_r0_7", 16'hD007, 2, 0, 1'b0);
    expect_ev(EV_WR, 3'd1, 16'hFFF9);
    do_instr("mov_r1_m7", 16'hD1F9, 2, 0, 1'b0);
    expect_ev(EV_WR, 3'd1, 16'h0002);
    do_instr("mov_r1_2", 16'hD102, 2, 0, 1'b0);
    expect_ev(EV_WR, 3'd2, 16'd16);          // 2 + (7<<1)
    do_instr("add", 16'hA148, 5, 0, 1'b0);
    expect_ev(EV_ST, 3'd0, 16'hFFF4);        // 2 - 14 = -12
    do_instr("cmp", 16'hA908, 4, 0, 1'b0);
    expect_ev(EV_WR, 3'd2, 16'hFFF1);        // ~(7<<1)
    do_instr("mvn", 16'hB848, 4, 0, 1'b0);
    expect_ev(EV_WR, 3'd3, 16'd9);           // ADD R3,R1,R0 = 2 + 7
    do_instr("load_blocked", 16'hA160, 5, 3, 1'b0);
    check("load_blocked_ir", {16'd0, bus.sximm8}, 32'h0060);
    expect_ev(EV_BAD, 3'd0, 16'h0000);
    do_instr("illegal", 16'h0000, 1, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
